i2c_target_regfile: RTL and testbench

I2C target (responder) with 16-bit register addressing, the opposite end of the ToF I2C controller. It oversamples `SCL_in`/`SDA_in` on the system clock, decodes START/STOP, matches a 7-bit device address, and bridges transfers onto a byte-wide register-file port. It serves as the ToF sensor model in loopback and hardware-in-loop benches, and as an on-FPGA config target. It never stretches the clock.

---
 rtl/i2c_target_regfile.sv | 195 +++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regfile.sv
// I2C target with 16-bit register pointer, bridging bus transfers onto a byte-wide register-file port.
// Oversamples SCL/SDA on the system clock; never stretches SCL.
module i2c_target_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h29
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        SCL_in,
  input  logic        SDA_in,
  output logic        SDA_out,
  output logic        SDA_t,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wr_data,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  input  logic [7:0]  mem_rd_data,
  output logic        busy,
  output logic        nack_err
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_DEV_ADDR, ST_ACK_DEV, ST_REG_HI, ST_ACK_HI, ST_REG_LO, ST_ACK_LO,
    ST_WR_DATA, ST_ACK_WR, ST_RD_LOAD, ST_RD_DATA, ST_RD_ACK, ST_WAIT_STOP
  } state_t;

  state_t      state;
  logic        scl_p0, scl_p1, scl_p2;
  logic        sda_p0, sda_p1, sda_p2;
  logic        fall_d;
  logic [7:0]  sr;
  logic [2:0]  cnt;
  logic        rw;
  logic        ack_on;
  logic        ld;
  logic        scl_rise, scl_fall, start_cond, stop_cond;
  logic [7:0]  byte_in;

  // p0/p1 synchronize the pins, p2 is the history flop for edge detection
  assign scl_rise   = scl_p1 & ~scl_p2;
  assign scl_fall   = ~scl_p1 & scl_p2;
  assign start_cond = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_cond  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;
  assign byte_in    = {sr[6:0], sda_p1};

  always_ff @(posedge clock) begin
    if (reset) begin
      {scl_p0, scl_p1, scl_p2} <= 3'b111;
      {sda_p0, sda_p1, sda_p2} <= 3'b111;
      fall_d      <= 1'b0;
      state       <= ST_IDLE;
      SDA_out     <= 1'b1;
      SDA_t       <= 1'b1;
      mem_addr    <= 16'h0000;
      mem_wr_data <= 8'h00;
      mem_wr_en   <= 1'b0;
      mem_rd_en   <= 1'b0;
      busy        <= 1'b0;
      nack_err    <= 1'b0;
      ack_on      <= 1'b0;
      ld          <= 1'b0;
      cnt         <= 3'd0;
      rw          <= 1'b0;
    end else begin
      scl_p0 <= SCL_in;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= SDA_in;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;
      // SDA changes one clock after the detected SCL fall
      fall_d    <= scl_fall;
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
      nack_err  <= 1'b0;
      if (mem_wr_en) mem_addr <= mem_addr + 16'd1;

      if (start_cond) begin
        state   <= ST_DEV_ADDR;
        cnt     <= 3'd0;
        ack_on  <= 1'b0;
        busy    <= 1'b0;
        SDA_t   <= 1'b1;
        SDA_out <= 1'b1;
      end else if (stop_cond) begin
        state   <= ST_IDLE;
        busy    <= 1'b0;
        SDA_t   <= 1'b1;
        SDA_out <= 1'b1;
      end else begin
        case (state)
          ST_IDLE, ST_WAIT_STOP: ;
          ST_DEV_ADDR: if (scl_rise) begin
            sr  <= byte_in;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (byte_in[7:1] == DEV_ADDR) begin
                rw     <= byte_in[0];
                ack_on <= 1'b0;
                state  <= ST_ACK_DEV;
              end else begin
                nack_err <= 1'b1;
                state    <= ST_WAIT_STOP;
              end
            end
          end
          ST_REG_HI, ST_REG_LO, ST_WR_DATA: if (scl_rise) begin
            sr  <= byte_in;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              ack_on <= 1'b0;
              if (state == ST_REG_HI) state <= ST_ACK_HI;
              else if (state == ST_REG_LO) state <= ST_ACK_LO;
              else begin
                mem_wr_data <= byte_in;
                state       <= ST_ACK_WR;
              end
            end
          end
          // First fall drives the ACK low, second fall releases it and acts on the byte
          ST_ACK_DEV, ST_ACK_HI, ST_ACK_LO, ST_ACK_WR: if (fall_d) begin
            if (!ack_on) begin
              ack_on  <= 1'b1;
              SDA_t   <= 1'b0;
              SDA_out <= 1'b0;
              if (state == ST_ACK_DEV) busy <= 1'b1;
              if (state == ST_ACK_WR) mem_wr_en <= 1'b1;
            end else begin
              ack_on  <= 1'b0;
              SDA_t   <= 1'b1;
              SDA_out <= 1'b1;
              cnt     <= 3'd0;
              case (state)
                ST_ACK_DEV: if (rw) begin
                  mem_rd_en <= 1'b1;
                  ld        <= 1'b0;
                  state     <= ST_RD_LOAD;
                end else state <= ST_REG_HI;
                ST_ACK_HI: begin
                  mem_addr[15:8] <= sr;
                  state          <= ST_REG_LO;
                end
                ST_ACK_LO: begin
                  mem_addr[7:0] <= sr;
                  state         <= ST_WR_DATA;
                end
                default: state <= ST_WR_DATA;
              endcase
            end
          end
          ST_RD_LOAD: begin
            if (!ld) begin
              sr <= mem_rd_data;
              ld <= 1'b1;
            end else begin
              SDA_t   <= sr[7];
              SDA_out <= sr[7];
              cnt     <= 3'd0;
              state   <= ST_RD_DATA;
            end
          end
          ST_RD_DATA: if (fall_d) begin
            if (cnt == 3'd7) begin
              SDA_t    <= 1'b1;
              SDA_out  <= 1'b1;
              mem_addr <= mem_addr + 16'd1;
              ack_on   <= 1'b0;
              state    <= ST_RD_ACK;
            end else begin
              sr      <= {sr[6:0], 1'b0};
              SDA_t   <= sr[6];
              SDA_out <= sr[6];
              cnt     <= cnt + 3'd1;
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              if (sda_p1) begin
                nack_err <= 1'b1;
                busy     <= 1'b0;
                state    <= ST_WAIT_STOP;
              end else ack_on <= 1'b1;
            end else if (fall_d && ack_on) begin
              ack_on    <= 1'b0;
              mem_rd_en <= 1'b1;
              ld        <= 1'b0;
              state     <= ST_RD_LOAD;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bus-level controller model with scoreboard queues for
// register-file strobes and read bytes.
module tb_i2c_target_regfile;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_bus;
  logic        SDA_out, SDA_t;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wr_data, mem_rd_data;
  logic        mem_wr_en, mem_rd_en, busy, nack_err;

  int errors = 0;
  int checks = 0;
  int wr_seen = 0;
  int rd_seen = 0;
  int nack_seen = 0;
  bit sda_driven = 1'b0;

  logic [23:0] wrq[$];
  logic [15:0] rdaq[$];
  logic [7:0]  rdq[$];

  always #5 clock = ~clock;

  assign sda_bus     = sda_m & (SDA_t | SDA_out);
  assign mem_rd_data = mem_addr[7:0] ^ 8'hFF;

  i2c_target_regfile #(.DEV_ADDR(7'h29)) dut (
    .clock(clock), .reset(reset), .SCL_in(scl), .SDA_in(sda_bus),
    .SDA_out(SDA_out), .SDA_t(SDA_t), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .busy(busy), .nack_err(nack_err)
  );

  always @(negedge clock) begin
    if (!reset) begin
      if (SDA_t == 1'b0) sda_driven = 1'b1;
      if (nack_err) nack_seen++;
      if (mem_wr_en) begin
        logic [23:0] exp_w;
        wr_seen++;
        checks++;
        if (wrq.size() == 0) begin
          errors++;
          $display("FAIL wr_strobe unexpected: addr=%h data=%h", mem_addr, mem_wr_data);
        end else begin
          exp_w = wrq.pop_front();
          if ({mem_addr, mem_wr_data} !== exp_w) begin
            errors++;
            $display("FAIL wr_strobe: got addr=%h data=%h, expected addr=%h data=%h",
                     mem_addr, mem_wr_data, exp_w[23:8], exp_w[7:0]);
          end
        end
      end
      if (mem_rd_en) begin
        logic [15:0] exp_a;
        rd_seen++;
        checks++;
        if (rdaq.size() == 0) begin
          errors++;
          $display("FAIL rd_strobe unexpected: addr=%h", mem_addr);
        end else begin
          exp_a = rdaq.pop_front();
          if (mem_addr !== exp_a) begin
            errors++;
            $display("FAIL rd_strobe: got addr=%h, expected %h", mem_addr, exp_a);
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
  endtask

  task automatic i2c_start();
    scl = 1'b0; wait_clk(3);
    sda_m = 1'b1; wait_clk(5);
    scl = 1'b1; wait_clk(4);
    sda_m = 1'b0; wait_clk(8);
  endtask

  task automatic i2c_stop();
    scl = 1'b0; wait_clk(3);
    sda_m = 1'b0; wait_clk(5);
    scl = 1'b1; wait_clk(4);
    sda_m = 1'b1; wait_clk(8);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit exp_ack, input string name);
    logic acked;
    for (int i = 7; i >= 0; i--) begin
      scl = 1'b0; wait_clk(3);
      sda_m = b[i]; wait_clk(5);
      scl = 1'b1; wait_clk(8);
    end
    scl = 1'b0; wait_clk(3);
    sda_m = 1'b1; wait_clk(5);
    scl = 1'b1; wait_clk(4);
    acked = ~sda_bus;
    checks++;
    if (acked !== exp_ack) begin
      errors++;
      $display("FAIL %s ack: got %0b, expected %0b", name, acked, exp_ack);
    end
    wait_clk(4);
  endtask

  task automatic recv_byte(input logic [7:0] exp, input bit do_ack, input string name);
    logic [7:0] got;
    logic [7:0] exp_b;
    rdq.push_back(exp);
    for (int i = 7; i >= 0; i--) begin
      scl = 1'b0; wait_clk(3);
      sda_m = 1'b1; wait_clk(5);
      scl = 1'b1; wait_clk(4);
      got[i] = sda_bus;
      wait_clk(4);
    end
    exp_b = rdq.pop_front();
    checks++;
    if (got !== exp_b) begin
      errors++;
      $display("FAIL %s data: got %h, expected %h", name, got, exp_b);
    end
    scl = 1'b0; wait_clk(3);
    sda_m = do_ack ? 1'b0 : 1'b1; wait_clk(5);
    scl = 1'b1; wait_clk(8);
  endtask

  task automatic test_reset();
    wait_clk(5);
    reset = 1'b0;
    wait_clk(2);
    checks += 8;
    if (SDA_out !== 1'b1) begin errors++; $display("FAIL reset SDA_out: got %b, expected 1", SDA_out); end
    if (SDA_t !== 1'b1) begin errors++; $display("FAIL reset SDA_t: got %b, expected 1", SDA_t); end
    if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset mem_addr: got %h, expected 0000", mem_addr); end
    if (mem_wr_data !== 8'h00) begin errors++; $display("FAIL reset mem_wr_data: got %h, expected 00", mem_wr_data); end
    if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset mem_wr_en: got %b, expected 0", mem_wr_en); end
    if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset mem_rd_en: got %b, expected 0", mem_rd_en); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b, expected 0", busy); end
    if (nack_err !== 1'b0) begin errors++; $display("FAIL reset nack_err: got %b, expected 0", nack_err); end
  endtask

  task automatic test_write();
    int w0 = wr_seen;
    i2c_start();
    send_byte(8'h52, 1'b1, "wr_dev");
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b, expected 1", busy); end
    send_byte(8'h01, 1'b1, "wr_hi");
    send_byte(8'h10, 1'b1, "wr_lo");
    wrq.push_back({16'h0110, 8'hA5});
    send_byte(8'hA5, 1'b1, "wr_d0");
    wrq.push_back({16'h0111, 8'h3C});
    send_byte(8'h3C, 1'b1, "wr_d1");
    i2c_stop();
    checks += 3;
    if (mem_addr !== 16'h0112) begin errors++; $display("FAIL wr_addr_after: got %h, expected 0112", mem_addr); end
    if (wr_seen - w0 !== 2) begin errors++; $display("FAIL wr_count: got %0d, expected 2", wr_seen - w0); end
    if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_after: got %b, expected 0", busy); end
  endtask

  task automatic test_ptr_read();
    int r0 = rd_seen;
    int n0 = nack_seen;
    i2c_start();
    send_byte(8'h52, 1'b1, "pr_dev_w");
    send_byte(8'h00, 1'b1, "pr_hi");
    send_byte(8'h0F, 1'b1, "pr_lo");
    i2c_stop();
    i2c_start();
    rdaq.push_back(16'h000F);
    send_byte(8'h53, 1'b1, "pr_dev_r");
    rdaq.push_back(16'h0010);
    recv_byte(8'hF0, 1'b1, "pr_rd0");
    rdaq.push_back(16'h0011);
    recv_byte(8'hEF, 1'b1, "pr_rd1");
    recv_byte(8'hEE, 1'b0, "pr_rd2");
    checks++;
    if (nack_seen - n0 !== 1) begin errors++; $display("FAIL pr_nack: got %0d pulses, expected 1", nack_seen - n0); end
    i2c_stop();
    checks += 3;
    if (rd_seen - r0 !== 3) begin errors++; $display("FAIL pr_rd_count: got %0d, expected 3", rd_seen - r0); end
    if (SDA_t !== 1'b1) begin errors++; $display("FAIL pr_released: got SDA_t=%b, expected 1", SDA_t); end
    if (mem_addr !== 16'h0012) begin errors++; $display("FAIL pr_addr_after: got %h, expected 0012", mem_addr); end
  endtask

  task automatic test_addr_miss();
    int w0 = wr_seen;
    int r0 = rd_seen;
    int n0 = nack_seen;
    sda_driven = 1'b0;
    i2c_start();
    send_byte(8'h54, 1'b0, "miss_dev");
    send_byte(8'h00, 1'b0, "miss_b1");
    i2c_stop();
    checks += 4;
    if (sda_driven !== 1'b0) begin errors++; $display("FAIL miss_sda_driven: got %b, expected 0", sda_driven); end
    if (nack_seen - n0 !== 1) begin errors++; $display("FAIL miss_nack: got %0d pulses, expected 1", nack_seen - n0); end
    if ((wr_seen - w0) + (rd_seen - r0) !== 0) begin
      errors++; $display("FAIL miss_strobes: got %0d, expected 0", (wr_seen - w0) + (rd_seen - r0));
    end
    if (busy !== 1'b0) begin errors++; $display("FAIL miss_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_repeated_start();
    int w0 = wr_seen;
    int n0 = nack_seen;
    i2c_start();
    send_byte(8'h52, 1'b1, "rs_dev_w");
    send_byte(8'h12, 1'b1, "rs_hi");
    i2c_start();
    rdaq.push_back(16'h1212);
    send_byte(8'h53, 1'b1, "rs_dev_r");
    recv_byte(8'hED, 1'b0, "rs_rd");
    i2c_stop();
    checks += 3;
    if (mem_addr !== 16'h1213) begin errors++; $display("FAIL rs_addr_after: got %h, expected 1213", mem_addr); end
    if (wr_seen - w0 !== 0) begin errors++; $display("FAIL rs_writes: got %0d, expected 0", wr_seen - w0); end
    if (nack_seen - n0 !== 1) begin errors++; $display("FAIL rs_nack: got %0d pulses, expected 1", nack_seen - n0); end
  endtask

  task automatic test_wrap();
    i2c_start();
    send_byte(8'h52, 1'b1, "wrap_dev");
    send_byte(8'hFF, 1'b1, "wrap_hi");
    send_byte(8'hFF, 1'b1, "wrap_lo");
    wrq.push_back({16'hFFFF, 8'h11});
    send_byte(8'h11, 1'b1, "wrap_d0");
    wrq.push_back({16'h0000, 8'h22});
    send_byte(8'h22, 1'b1, "wrap_d1");
    i2c_stop();
    checks++;
    if (mem_addr !== 16'h0001) begin errors++; $display("FAIL wrap_addr_after: got %h, expected 0001", mem_addr); end
  endtask

  task automatic test_reset_mid_read();
    i2c_start();
    send_byte(8'h52, 1'b1, "rst_dev_w");
    send_byte(8'h00, 1'b1, "rst_hi");
    send_byte(8'hFF, 1'b1, "rst_lo");
    i2c_stop();
    i2c_start();
    rdaq.push_back(16'h00FF);
    send_byte(8'h53, 1'b1, "rst_dev_r");
    scl = 1'b0;
    wait_clk(10);
    checks++;
    if (SDA_t !== 1'b0) begin errors++; $display("FAIL rst_msb_drive: got SDA_t=%b, expected 0", SDA_t); end
    reset = 1'b1;
    wait_clk(1);
    checks += 3;
    if (SDA_t !== 1'b1) begin errors++; $display("FAIL rst_release: got SDA_t=%b, expected 1", SDA_t); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, expected 0", busy); end
    if (mem_addr !== 16'h0000) begin errors++; $display("FAIL rst_addr: got %h, expected 0000", mem_addr); end
    wait_clk(2);
    reset = 1'b0;
    wait_clk(4);
    i2c_start();
    send_byte(8'h52, 1'b1, "post_dev");
    send_byte(8'h20, 1'b1, "post_hi");
    send_byte(8'h00, 1'b1, "post_lo");
    wrq.push_back({16'h2000, 8'h77});
    send_byte(8'h77, 1'b1, "post_d0");
    i2c_stop();
    checks++;
    if (mem_addr !== 16'h2001) begin errors++; $display("FAIL post_addr_after: got %h, expected 2001", mem_addr); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_ptr_read();
    test_addr_miss();
    test_repeated_start();
    test_wrap();
    test_reset_mid_read();
    wait_clk(4);
    checks++;
    if (wrq.size() + rdaq.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: got %0d pending, expected 0", wrq.size() + rdaq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
